// File: rtl/sd_spi_cmd.sv
// rtl/sd_spi_cmd.sv - SPI-mode SD command engine: init clocks, framed command with CRC7, response capture

module sd_crc7 #(
  parameter int W = 40
) (
  input  logic [W-1:0] data,
  output logic [6:0]   crc
);

  // CRC7 (x^7 + x^3 + 1, zero seed) unrolled over the frame prefix, MSB first
  always_comb begin
    logic fb;
    fb  = 1'b0;
    crc = 7'd0;
    for (int i = W - 1; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
  end

endmodule

module sd_spi_cmd #(
  parameter int LOWFREQ_POWER2  = 6,
  parameter int HIGHFREQ_POWER2 = 1,
  parameter int INIT_CLOCKS     = 80,
  parameter int RESP_TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  command,
  input  logic [31:0] arg,
  input  logic        resp_long,
  input  logic        fast,
  output logic [39:0] response,
  output logic        response_ready,
  output logic        timeout,
  input  logic        miso,
  output logic        mosi,
  output logic        sdclk,
  output logic        sd_chip_select
);

  localparam int DW = LOWFREQ_POWER2 + 1;
  localparam logic [DW-1:0] SLOW_MASK   = DW'((1 << LOWFREQ_POWER2) - 1);
  localparam logic [DW-1:0] FAST_MASK   = DW'((1 << HIGHFREQ_POWER2) - 1);
  localparam logic [15:0]   INIT_PULSES = 16'(INIT_CLOCKS);
  localparam logic [15:0]   WAIT_BITS   = 16'(8 * RESP_TIMEOUT);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RECV,
    S_TRAIL
  } state_t;

  state_t        state, state_next;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_mask;
  logic          tick, rise, fall, active, accept, cnt_evt;
  logic          fast_q, long_q, timeout_q, sdclk_q;
  logic [47:0]   frame_sr;
  logic [39:0]   resp_sr;
  logic [15:0]   cnt;
  logic [6:0]    crc;

  sd_crc7 #(.W(40)) u_crc (
    .data ({2'b01, command, arg}),
    .crc  (crc)
  );

  // The latched speed selects which low counter bits must be all ones for a tick,
  // so a mid-command change on the fast input cannot alter the sdclk period.
  assign div_mask = fast_q ? FAST_MASK : SLOW_MASK;
  assign tick     = ((div_cnt & div_mask) == div_mask);
  assign active   = (state != S_IDLE);
  assign rise     = active && tick && !sdclk_q;
  assign fall     = active && tick && sdclk_q;
  assign accept   = (state == S_IDLE) && cmd_valid;
  assign sdclk    = sdclk_q;

  // Free-running divider, restarted on command accept so the first half-period is full length
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         div_cnt <= '0;
    else if (accept) div_cnt <= '0;
    else             div_cnt <= div_cnt + DW'(1);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_next;
  end

  // Next-state logic; exits to IDLE/TRAIL/WAIT happen on sdclk falling edges so sdclk ends low
  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  if (fall && cnt == INIT_PULSES - 16'd1) state_next = S_IDLE;
      S_IDLE:  if (cmd_valid) state_next = S_SEND;
      S_SEND:  if (fall && cnt == 16'd47) state_next = S_WAIT;
      S_WAIT: begin
        if (rise && !miso)                   state_next = S_RECV;
        else if (fall && cnt == WAIT_BITS)   state_next = S_TRAIL;
      end
      S_RECV:  if (fall && cnt == (long_q ? 16'd40 : 16'd8)) state_next = S_TRAIL;
      S_TRAIL: if (fall && cnt == 16'd7) state_next = S_IDLE;
      default: state_next = S_INIT;
    endcase
  end

  // Pin outputs decoded from state; mosi follows the frame MSB only while sending
  always_comb begin
    cmd_ready      = 1'b0;
    sd_chip_select = 1'b1;
    mosi           = 1'b1;
    case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_SEND: begin
        sd_chip_select = 1'b0;
        mosi           = frame_sr[47];
      end
      S_WAIT, S_RECV: sd_chip_select = 1'b0;
      default: ;
    endcase
  end

  // Pulses are counted on falling edges, received bits on rising edges; RECV starts at 1 for the start bit
  always_comb begin
    cnt_evt = 1'b0;
    case (state)
      S_INIT, S_SEND, S_TRAIL: cnt_evt = fall;
      S_WAIT, S_RECV:          cnt_evt = rise;
      default:                 cnt_evt = 1'b0;
    endcase
  end

  // Shared bit/pulse counter, cleared on every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= 16'd0;
    else if (state_next != state) cnt <= (state_next == S_RECV) ? 16'd1 : 16'd0;
    else if (cnt_evt)             cnt <= cnt + 16'd1;
  end

  // sdclk toggles on each divider tick while the engine is busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  sdclk_q <= 1'b0;
    else if (active && tick)  sdclk_q <= ~sdclk_q;
  end

  // Command latch and outgoing frame shifter (advances on sdclk falling edges)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_sr <= '1;
      fast_q   <= 1'b0;
      long_q   <= 1'b0;
    end else if (accept) begin
      frame_sr <= {2'b01, command, arg, crc, 1'b1};
      fast_q   <= fast;
      long_q   <= resp_long;
    end else if (state == S_SEND && fall) begin
      frame_sr <= {frame_sr[46:0], 1'b1};
    end
  end

  // Response shifter: first zero in WAIT is the R1 MSB, RECV shifts the rest
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_sr   <= '0;
      timeout_q <= 1'b0;
    end else if (accept) begin
      resp_sr   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (rise && ((state == S_WAIT && !miso) || state == S_RECV))
        resp_sr <= {resp_sr[38:0], miso};
      if (state == S_WAIT && state_next == S_TRAIL)
        timeout_q <= 1'b1;
    end
  end

  // Publish the result and pulse response_ready as TRAIL hands back to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      response       <= '0;
      timeout        <= 1'b0;
      response_ready <= 1'b0;
    end else if (state == S_TRAIL && state_next == S_IDLE) begin
      response       <= timeout_q ? 40'hFF_FFFF_FFFF : resp_sr;
      timeout        <= timeout_q;
      response_ready <= 1'b1;
    end else begin
      response_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sd_spi_cmd.sv
// tb/tb_sd_spi_cmd.sv - directed self-checking bench for sd_spi_cmd

module tb_sd_spi_cmd;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  command;
  logic [31:0] arg;
  logic        resp_long;
  logic        fast;
  logic [39:0] response;
  logic        response_ready;
  logic        timeout;
  logic        miso = 1'b1;
  logic        mosi;
  logic        sdclk;
  logic        sd_chip_select;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] rsp_pat  = '0;
  int          rsp_len  = 0;
  logic [47:0] rx_frame = '0;
  int          rx_bits  = 0;
  int          rsp_idx  = 0;
  int          frames_seen = 0;

  sd_spi_cmd dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .command        (command),
    .arg            (arg),
    .resp_long      (resp_long),
    .fast           (fast),
    .response       (response),
    .response_ready (response_ready),
    .timeout        (timeout),
    .miso           (miso),
    .mosi           (mosi),
    .sdclk          (sdclk),
    .sd_chip_select (sd_chip_select)
  );

  always #5 clk = ~clk;

  // Card model: capture 48 frame bits on rising edges, then play rsp_pat back on falling edges
  always @(posedge sdclk or negedge sdclk or posedge sd_chip_select) begin
    if (sd_chip_select) begin
      rx_bits = 0;
      rsp_idx = 0;
      miso    = 1'b1;
    end else if (sdclk) begin
      if (rx_bits < 48) begin
        rx_frame = {rx_frame[46:0], mosi};
        rx_bits++;
        if (rx_bits == 48) frames_seen++;
      end
    end else if (rx_bits == 48) begin
      miso = (rsp_idx < rsp_len) ? rsp_pat[rsp_len - 1 - rsp_idx] : 1'b1;
      rsp_idx++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic watch_init(input string tag);
    int pulses, bad, rdy, run, toggles, hmin, hmax;
    logic prev;
    pulses = 0; bad = 0; rdy = 0; run = 0; toggles = 0; hmin = 1 << 30; hmax = 0;
    prev = sdclk;
    for (int i = 0; i < 12000 && !cmd_ready; i++) begin
      @(negedge clk);
      run++;
      if (sdclk !== prev) begin
        toggles++;
        if (toggles > 1) begin
          if (run < hmin) hmin = run;
          if (run > hmax) hmax = run;
        end
        run = 0;
        if (sdclk) pulses++;
      end
      prev = sdclk;
      if (!cmd_ready && (sd_chip_select !== 1'b1 || mosi !== 1'b1)) bad++;
      if (response_ready) rdy++;
    end
    check({tag, "_pulses"}, pulses, 80);
    check({tag, "_hp_min"}, hmin, 64);
    check({tag, "_hp_max"}, hmax, 64);
    check({tag, "_cs_mosi_high"}, bad, 0);
    check({tag, "_no_ready"}, rdy, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  task automatic send_cmd(input logic [5:0] c, input logic [31:0] a, input logic lng, input logic f);
    @(negedge clk);
    command = c; arg = a; resp_long = lng; fast = f; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input int budget, input int inject_at,
                         output int rdy, output int pulses, output int trail,
                         output int hmin, output int hmax);
    int run, post, toggles;
    logic prev;
    rdy = 0; pulses = 0; trail = 0; hmin = 1 << 30; hmax = 0;
    run = 0; post = 0; toggles = 0;
    prev = sdclk;
    for (int i = 0; i < budget && post < 400; i++) begin
      @(negedge clk);
      if (i == inject_at) begin
        cmd_valid = 1'b1; command = 6'd8; arg = 32'h1AA; resp_long = 1'b1; fast = 1'b0;
      end else if (i == inject_at + 1) begin
        cmd_valid = 1'b0;
      end
      run++;
      if (sdclk !== prev) begin
        toggles++;
        if (toggles > 1) begin
          if (run < hmin) hmin = run;
          if (run > hmax) hmax = run;
        end
        run = 0;
        if (sdclk) begin
          pulses++;
          if (sd_chip_select) trail++;
        end
      end
      prev = sdclk;
      if (response_ready) rdy++;
      if (rdy > 0) post++;
    end
  endtask

  int   rdy, pulses, trail, hmin, hmax, f0, edges;
  logic prev_clk;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; command = '0; arg = '0; resp_long = 1'b0; fast = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs", sd_chip_select, 1);
    check("rst_mosi", mosi, 1);
    check("rst_sdclk", sdclk, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_response", response, 0);
    check("rst_resp_ready", response_ready, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;
    watch_init("init");

    // CMD0, slow, R1 0x01 after two idle bytes
    rsp_pat = 64'hFFFF01; rsp_len = 24; f0 = frames_seen;
    send_cmd(6'd0, 32'h0, 1'b0, 1'b0);
    run_cmd(14000, -1, rdy, pulses, trail, hmin, hmax);
    check("cmd0_ready_pulses", rdy, 1);
    check("cmd0_frames", frames_seen - f0, 1);
    check("cmd0_frame", rx_frame, 48'h40_0000_0000_95);
    check("cmd0_response", response, 40'h00_0000_0001);
    check("cmd0_timeout", timeout, 0);
    check("cmd0_pulses", pulses, 80);
    check("cmd0_trail", trail, 8);
    check("cmd0_hp_min", hmin, 64);
    check("cmd0_hp_max", hmax, 64);

    // CMD8, fast, R7
    rsp_pat = 64'h01_0000_01AA; rsp_len = 40; f0 = frames_seen;
    send_cmd(6'd8, 32'h1AA, 1'b1, 1'b1);
    run_cmd(3000, -1, rdy, pulses, trail, hmin, hmax);
    check("cmd8_ready_pulses", rdy, 1);
    check("cmd8_frames", frames_seen - f0, 1);
    check("cmd8_frame", rx_frame, 48'h48_0000_01AA_87);
    check("cmd8_response", response, 40'h01_0000_01AA);
    check("cmd8_timeout", timeout, 0);
    check("cmd8_pulses", pulses, 96);
    check("cmd8_hp_min", hmin, 2);
    check("cmd8_hp_max", hmax, 2);

    // No start bit: miso idles high
    rsp_len = 0; f0 = frames_seen;
    send_cmd(6'd55, 32'h0, 1'b0, 1'b1);
    run_cmd(3000, -1, rdy, pulses, trail, hmin, hmax);
    check("to_ready_pulses", rdy, 1);
    check("to_response", response, 40'hFF_FFFF_FFFF);
    check("to_timeout", timeout, 1);
    check("to_pulses", pulses, 184);
    check("to_trail", trail, 8);

    // cmd_valid (and a fast change) during SEND is ignored
    rsp_pat = 64'hFFFF01; rsp_len = 24; f0 = frames_seen;
    send_cmd(6'd0, 32'h0, 1'b0, 1'b1);
    run_cmd(3000, 10, rdy, pulses, trail, hmin, hmax);
    check("ign_ready_pulses", rdy, 1);
    check("ign_frames", frames_seen - f0, 1);
    check("ign_frame", rx_frame, 48'h40_0000_0000_95);
    check("ign_response", response, 40'h00_0000_0001);
    check("ign_timeout", timeout, 0);
    check("ign_pulses", pulses, 80);
    check("ign_hp_max", hmax, 2);
    check("ign_cmd_ready", cmd_ready, 1);

    // Reset in the middle of RECV
    rsp_pat = 64'h01_0000_01AA; rsp_len = 40;
    send_cmd(6'd8, 32'h1AA, 1'b1, 1'b1);
    edges = 0; prev_clk = sdclk;
    for (int i = 0; i < 2000 && edges < 60; i++) begin
      @(negedge clk);
      if (sdclk && !prev_clk && !sd_chip_select) edges++;
      prev_clk = sdclk;
    end
    check("abort_reached_recv", edges, 60);
    rst = 1'b1;
    #1;
    check("abort_cs", sd_chip_select, 1);
    check("abort_sdclk", sdclk, 0);
    check("abort_cmd_ready", cmd_ready, 0);
    rdy = 0;
    repeat (4) begin
      @(negedge clk);
      if (response_ready) rdy++;
    end
    check("abort_no_ready", rdy, 0);
    check("abort_response", response, 0);
    rst = 1'b0;
    watch_init("reinit");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
